qspi_flash_reader: RTL and testbench
====================================

# qspi_flash_reader

AHB-Lite read-only flash controller that fetches 32-bit words from an SPI NOR flash using the single-lane READ command (0x03, 24-bit address). It drives the flash-reader (`fr_*`) side of the flash-writer mux. While write-enable is clear, its pins reach the flash unchanged; while it is set, the bit-bang writer owns the pins. Each AHB read stalls the bus with HREADYOUT low, runs a complete CE-framed SPI transaction, and returns the word little-endian.

## Interface
- CMD, 8'h03, read opcode shifted out MSB-first before the address.
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  reset; **one clock; reset is synchronous and active-low**.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; bits [23:2] used, the rest ignored.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer.
- HWRITE  in  1  1 = write, which is accepted and ignored.
- HREADY  in  1  bus ready; qualifies the address phase.
- HSIZE  in  3  ignored; a full word is always returned.
- HWDATA  in  32  ignored.
- HREADYOUT  out  1  0 while a read is in flight.
- HRDATA  out  32  registered read data.
- fr_sck  out  1  SPI clock, mode 0, idle low.
- fr_ce_n  out  1  chip enable, active low.
- fr_din  in  4  flash data in; only [1] (MISO) is used.
- fr_dout  out  4  flash data out; [0] is MOSI, [3:1] are tied 0.
- fr_douten  out  4  output enables; [0] is 1 during the command/address phase, otherwise 0; [3:1] are tied 0.

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1] & ~HWRITE at a rising edge (edge E0) in IDLE or DONE.
- At E0:
  - Latch flash address A = {HADDR[23:2], 2'b00}.
  - Load the 32-bit TX shift register with {CMD, A}.
  - Set state TX, fr_ce_n=0, fr_sck=0, HREADYOUT=0.
- A write or idle-type access at an accept point does nothing: HREADYOUT stays 1 and HRDATA is unchanged.
- FSM: IDLE -> TX -> RX -> DONE.
  - DONE -> TX if a new read is accepted in that cycle, else DONE -> IDLE.
- Bit timing, in both TX and RX: a phase flag toggles every HCLK, and fr_sck = phase. Each bit is 2 HCLK: sck low, then sck high.
- TX: 32 bits, MSB first.
  - fr_dout[0] holds the current bit during both of its cycles.
  - A new bit is presented at the edge where sck goes 1->0.
  - fr_douten = 4'b0001.
- RX: 32 bits.
  - fr_douten = 4'b0000 and fr_dout = 0.
  - fr_din[1] is sampled at the edge where sck goes 0->1.
  - Bits shift into the RX register MSB-first per byte.
- Byte assembly: bytes b0..b3 arrive from addresses A..A+3, and HRDATA = {b3, b2, b1, b0}.
- DONE (exactly one cycle):
  - fr_ce_n=1, fr_sck=0, fr_douten=0.
  - HRDATA is loaded with the assembled word and HREADYOUT=1.
- HRDATA holds its value until the next read completes.
- Writes never start flash activity and add no wait states.

## Timing
- Reset values: state=IDLE, HREADYOUT=1, HRDATA=0, fr_ce_n=1, fr_sck=0, fr_dout=0, fr_douten=0.
- Reset asserted mid-transfer: at the next edge the block aborts to IDLE with reset values on every output. No partial data is written to HRDATA.
- Read latency:
  - HREADYOUT=0 for exactly 128 HCLK after E0 (64 TX + 64 RX cycles).
  - HREADYOUT=1 on the 129th cycle (DONE), in which the data is valid.
- fr_ce_n is low for exactly 128 cycles per read.
- SCK frequency is HCLK/2, with 64 rising edges per read.
- Back-to-back reads: the next address phase is accepted at the DONE edge, so fr_ce_n is high for exactly 1 HCLK between frames.
- Bit counter: 5-bit, plus a TX/RX state bit. It wraps 31 -> 0 on each state change. There is no other arithmetic.

## Test plan
- Reset: hold HRESETn=0 for 3 edges mid-idle -> HREADYOUT=1, HRDATA=0, fr_ce_n=1, fr_sck=0, fr_douten=0.
- Single read: HADDR=0x0000_0100, flash model returns 0x11,0x22,0x33,0x44 -> expect all of:
  - MOSI stream 0x03_000100.
  - 64 sck rising edges.
  - HREADYOUT low for 128 cycles.
  - HRDATA=0x4433_2211.
- Unaligned read: HADDR=0x0000_0103, HSIZE=byte -> flash address 0x000100 on MOSI, full word returned.
- Back-to-back reads at 0x000 and 0x004 -> two CE frames separated by exactly 1 HCLK with fr_ce_n high; second HRDATA comes from bytes 4..7.
- Write access: HWRITE=1 to 0x10 -> HREADYOUT stays 1, fr_ce_n stays 1, no sck edges, HRDATA unchanged.
- Reset mid-read: assert HRESETn=0 at cycle 40 of TX -> next edge gives fr_ce_n=1, fr_sck=0, HREADYOUT=1; HRDATA keeps its pre-reset-cleared value 0.

Source files
------------

// File: rtl/qspi_flash_reader.sv
// AHB-Lite read-only SPI NOR flash reader: each read stalls the bus, runs one
// CE-framed READ (0x03 + 24-bit address) transaction and returns the word little-endian.
module qspi_flash_reader (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        fr_sck,
  output logic        fr_ce_n,
  input  logic [3:0]  fr_din,
  output logic [3:0]  fr_dout,
  output logic [3:0]  fr_douten
);

  localparam logic [7:0] CMD = 8'h03;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TX   = 2'd1;
  localparam logic [1:0] ST_RX   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic        phase_q,   phase_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_sr_q,   tx_sr_d;
  logic [31:0] rx_sr_q,   rx_sr_d;
  logic [31:0] hrdata_q,  hrdata_d;

  logic accept;
  logic busy;

  // Size, write data, upper address bits and unused data lanes do not affect a word fetch.
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HWDATA, HADDR[31:24], HADDR[1:0], fr_din[3:2], fr_din[0]};

  assign accept = HSEL & HREADY & HTRANS[1] & ~HWRITE;
  assign busy   = (state_q == ST_TX) || (state_q == ST_RX);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    hrdata_d  = hrdata_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d   = ST_TX;
          phase_d   = 1'b0;
          bit_cnt_d = 5'd0;
          tx_sr_d   = {CMD, HADDR[23:2], 2'b00};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TX: begin
        phase_d = ~phase_q;
        // The next bit is presented on the edge where sck falls.
        if (phase_q) begin
          tx_sr_d   = {tx_sr_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) state_d = ST_RX;
        end
      end

      ST_RX: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          rx_sr_d = {rx_sr_q[30:0], fr_din[1]};
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            state_d  = ST_DONE;
            // First byte received is the lowest address, so it lands in HRDATA[7:0].
            hrdata_d = {rx_sr_q[7:0], rx_sr_q[15:8], rx_sr_q[23:16], rx_sr_q[31:24]};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= 5'd0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign HREADYOUT = ~busy;
  assign HRDATA    = hrdata_q;
  assign fr_ce_n   = ~busy;
  assign fr_sck    = phase_q & busy;
  assign fr_dout   = {3'b000, (state_q == ST_TX) & tx_sr_q[31]};
  assign fr_douten = {3'b000, (state_q == ST_TX)};

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Self-checking bench for qspi_flash_reader: behavioural SPI NOR flash, table-driven
// accesses, randomized accesses and hand-written reset/back-to-back sequences.
module tb_qspi_flash_reader;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = 2'b00;
  logic        HWRITE  = 1'b0;
  logic        HREADY;
  logic [2:0]  HSIZE   = 3'd2;
  logic [31:0] HWDATA  = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        fr_sck;
  logic        fr_ce_n;
  logic [3:0]  fr_din;
  logic [3:0]  fr_dout;
  logic [3:0]  fr_douten;
  logic        miso = 1'b0;

  assign HREADY = HREADYOUT;
  assign fr_din = {2'b00, miso, 1'b0};

  always #5 HCLK = ~HCLK;

  qspi_flash_reader dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .fr_sck    (fr_sck),
    .fr_ce_n   (fr_ce_n),
    .fr_din    (fr_din),
    .fr_dout   (fr_dout),
    .fr_douten (fr_douten)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural flash: 1 KiB array aliased over the 24-bit space. It shifts in
  // command+address on rising sck and shifts data out on falling sck.
  logic [7:0]  mem [0:1023];
  int          rcount    = 0;
  int          sck_total = 0;
  logic [31:0] mosi_sr   = '0;

  always @(negedge fr_ce_n) begin
    rcount  = 0;
    mosi_sr = '0;
  end

  always @(posedge fr_sck) begin
    sck_total++;
    if (fr_ce_n === 1'b0) begin
      if (rcount < 32) mosi_sr = {mosi_sr[30:0], fr_dout[0]};
      rcount++;
    end
  end

  always @(negedge fr_sck) begin
    int k;
    if (fr_ce_n === 1'b0 && rcount >= 32 && rcount < 64) begin
      k    = rcount - 32;
      miso = mem[10'(mosi_sr[9:0] + 10'(k / 8))][7 - (k % 8)];
    end
  end

  function automatic logic [31:0] model_word(input logic [31:0] haddr);
    logic [9:0] a;
    a = {haddr[9:2], 2'b00};
    return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  typedef struct {
    logic [31:0] haddr;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        is_read;
  } vec_t;

  logic [31:0] exp_hrdata = '0;

  // Starts at a negedge with the DUT in IDLE or DONE; a read ends at the DONE negedge.
  task automatic access(input vec_t v, input string tag);
    int lows, ce_lows, oe_cycles, guard, sck0;
    sck0   = sck_total;
    HSEL   = v.hsel;
    HTRANS = v.htrans;
    HWRITE = v.hwrite;
    HADDR  = v.haddr;
    HSIZE  = v.hsize;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    if (v.is_read) begin
      lows = 0; ce_lows = 0; oe_cycles = 0; guard = 0;
      while (HREADYOUT !== 1'b1 && guard < 300) begin
        lows++;
        if (fr_ce_n === 1'b0) ce_lows++;
        if (fr_douten === 4'b0001) oe_cycles++;
        guard++;
        @(negedge HCLK);
      end
      exp_hrdata = model_word(v.haddr);
      check($sformatf("%s stall_cycles", tag), lows, 128);
      check($sformatf("%s ce_low_cycles", tag), ce_lows, 128);
      check($sformatf("%s mosi_oe_cycles", tag), oe_cycles, 64);
      check($sformatf("%s sck_rises", tag), rcount, 64);
      check($sformatf("%s mosi_stream", tag), mosi_sr, {8'h03, v.haddr[23:2], 2'b00});
      check($sformatf("%s done_ce_n", tag), {31'd0, fr_ce_n}, 32'd1);
      check($sformatf("%s hrdata", tag), HRDATA, exp_hrdata);
    end else begin
      check($sformatf("%s hreadyout", tag), {31'd0, HREADYOUT}, 32'd1);
      check($sformatf("%s ce_n", tag), {31'd0, fr_ce_n}, 32'd1);
      @(negedge HCLK);
      check($sformatf("%s hreadyout_next", tag), {31'd0, HREADYOUT}, 32'd1);
      check($sformatf("%s no_sck", tag), sck_total - sck0, 0);
      check($sformatf("%s hrdata_held", tag), HRDATA, exp_hrdata);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s hreadyout", tag), {31'd0, HREADYOUT}, 32'd1);
    check($sformatf("%s hrdata", tag), HRDATA, 32'd0);
    check($sformatf("%s ce_n", tag), {31'd0, fr_ce_n}, 32'd1);
    check($sformatf("%s sck", tag), {31'd0, fr_sck}, 32'd0);
    check($sformatf("%s douten", tag), {28'd0, fr_douten}, 32'd0);
    check($sformatf("%s dout", tag), {28'd0, fr_dout}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;

    vecs[0] = '{haddr: 32'h0000_0100, hsel: 1'b1, htrans: 2'b10, hwrite: 1'b0, hsize: 3'd2, is_read: 1'b1};
    vecs[1] = '{haddr: 32'h0000_0010, hsel: 1'b1, htrans: 2'b10, hwrite: 1'b1, hsize: 3'd2, is_read: 1'b0};
    vecs[2] = '{haddr: 32'h0000_0103, hsel: 1'b1, htrans: 2'b10, hwrite: 1'b0, hsize: 3'd0, is_read: 1'b1};
    vecs[3] = '{haddr: 32'h0000_0020, hsel: 1'b1, htrans: 2'b00, hwrite: 1'b0, hsize: 3'd2, is_read: 1'b0};
    vecs[4] = '{haddr: 32'h0000_0024, hsel: 1'b1, htrans: 2'b01, hwrite: 1'b0, hsize: 3'd2, is_read: 1'b0};
    vecs[5] = '{haddr: 32'h0000_0028, hsel: 1'b0, htrans: 2'b10, hwrite: 1'b0, hsize: 3'd2, is_read: 1'b0};
    vecs[6] = '{haddr: 32'hFFAB_C3FE, hsel: 1'b1, htrans: 2'b11, hwrite: 1'b0, hsize: 3'd1, is_read: 1'b1};
    vecs[7] = '{haddr: 32'h0012_3454, hsel: 1'b1, htrans: 2'b11, hwrite: 1'b1, hsize: 3'd2, is_read: 1'b0};

    // Reset held for three edges from power-up.
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_reset_outputs("reset_initial");
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i], $sformatf("vec%0d", i));
      @(negedge HCLK);
    end

    // Reset mid-idle after a read has left nonzero data in HRDATA.
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_reset_outputs("reset_idle");
    exp_hrdata = '0;
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Back-to-back: the second address phase is driven during the DONE cycle.
    v = '{haddr: 32'h0000_0000, hsel: 1'b1, htrans: 2'b10, hwrite: 1'b0, hsize: 3'd2, is_read: 1'b1};
    access(v, "b2b_first");
    v.haddr = 32'h0000_0004;
    v.htrans = 2'b11;
    access(v, "b2b_second");
    @(negedge HCLK);
    check("b2b_idle_after", {31'd0, fr_ce_n}, 32'd1);

    // Randomized accesses; read-ness follows the accept rule.
    for (int i = 0; i < 24; i++) begin
      v.haddr   = $urandom;
      v.hsel    = ($urandom_range(0, 3) != 0);
      v.htrans  = 2'($urandom);
      v.hwrite  = ($urandom_range(0, 2) == 0);
      v.hsize   = 3'($urandom_range(0, 2));
      v.is_read = v.hsel && v.htrans[1] && !v.hwrite;
      access(v, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge HCLK);
    end

    // Reset asserted during cycle 40 of the TX phase.
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0200;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (39) @(negedge HCLK);
    check("midreset_busy_before", {31'd0, fr_ce_n}, 32'd0);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    check_reset_outputs("reset_midread");
    exp_hrdata = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    v = '{haddr: 32'h0000_0100, hsel: 1'b1, htrans: 2'b10, hwrite: 1'b0, hsize: 3'd2, is_read: 1'b1};
    access(v, "after_reset_read");
    check("after_reset_word", HRDATA, 32'h4433_2211);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
